// File: rtl/switch_debounce3.sv
// ---------------------------------------------------------------------------
// switch_debounce3
//
// Debounces three raw mechanical switch levels (A, B, C) before they feed the
// downstream odd-zeros detector. Each bit is first brought into the clock
// domain through a two-flop synchronizer. A per-bit counter then measures how
// long the synchronized level has disagreed with the debounced output. The
// output only follows once the disagreement has lasted STABLE_CYCLES
// consecutive edges. Any return to the current output level before that
// restarts the count.
//
// Parameters
//   STABLE_CYCLES  consecutive disagreeing edges needed before sw_out follows
//                  (legal range 2 .. 2**CNT_WIDTH-1)
//   CNT_WIDTH      width of each per-bit stability counter
//
// Optional feature (macro DEBOUNCE_EVENT_CNT_EN)
//   When defined, an 8-bit wrapping count of accepted change events is
//   exposed on evt_cnt. When undefined, neither the port nor its logic exists.
//
// Ports
//   clk      in   1  rising-edge clock for all state
//   reset    in   1  synchronous, active-high reset
//   sw_in    in   3  raw asynchronous levels, bit2=A, bit1=B, bit0=C
//   sw_out   out  3  debounced levels
//   changed  out  1  registered one-cycle pulse, high in the cycle sw_out
//                    takes a new value
//   evt_cnt  out  8  accepted change events, modulo 256 (macro only)
// ---------------------------------------------------------------------------
module switch_debounce3 #(
    parameter int unsigned STABLE_CYCLES = 16,
    parameter int unsigned CNT_WIDTH     = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] sw_in,
    output logic [2:0] sw_out,
    output logic       changed
`ifdef DEBOUNCE_EVENT_CNT_EN
    ,
    output logic [7:0] evt_cnt
`endif
);

    localparam int unsigned NBITS = 3;

    // Terminal count value: reaching it while still disagreeing means the
    // input has now been different for STABLE_CYCLES consecutive edges.
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

    generate
        if (STABLE_CYCLES < 2 || STABLE_CYCLES > ((64'd1 << CNT_WIDTH) - 64'd1)) begin : g_bad_param
            $error("switch_debounce3: STABLE_CYCLES out of range for CNT_WIDTH");
        end
    endgenerate

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [NBITS-1:0]                s1_q;
    logic [NBITS-1:0]                s2_q;
    logic [NBITS-1:0][CNT_WIDTH-1:0] cnt_q;
    logic [NBITS-1:0][CNT_WIDTH-1:0] cnt_d;
    logic [NBITS-1:0]                sw_out_q;
    logic [NBITS-1:0]                sw_out_d;
    logic                            changed_q;
    logic                            changed_d;

    // -----------------------------------------------------------------------
    // Synchronizer: s1 may go metastable, s2 is the first usable sample.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= sw_in;
            s2_q <= s1_q;
        end
    end

    // -----------------------------------------------------------------------
    // Per-bit stability counters and output update.
    // The counter only runs while s2 disagrees with the output and is cleared
    // both on agreement (bounce) and on acceptance, so it is bounded by
    // CNT_LAST and can never wrap.
    // -----------------------------------------------------------------------
    always_comb begin
        cnt_d    = cnt_q;
        sw_out_d = sw_out_q;
        for (int i = 0; i < NBITS; i++) begin
            if (s2_q[i] == sw_out_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                sw_out_d[i] = s2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
        // Several bits accepted on the same edge still give one pulse.
        changed_d = |(sw_out_d ^ sw_out_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            sw_out_q  <= '0;
            changed_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            sw_out_q  <= sw_out_d;
            changed_q <= changed_d;
        end
    end

    assign sw_out  = sw_out_q;
    assign changed = changed_q;

`ifdef DEBOUNCE_EVENT_CNT_EN
    // -----------------------------------------------------------------------
    // Event counter: advances on the same edge that raises changed, so the
    // new count is visible in the cycle the pulse is high. Wraps naturally.
    // -----------------------------------------------------------------------
    logic [7:0] evt_cnt_q;
    logic [7:0] evt_cnt_d;

    always_comb begin
        evt_cnt_d = evt_cnt_q + {7'd0, changed_d};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            evt_cnt_q <= '0;
        end else begin
            evt_cnt_q <= evt_cnt_d;
        end
    end

    assign evt_cnt = evt_cnt_q;
`endif

endmodule

// File: tb/tb_switch_debounce3.sv
module tb_switch_debounce3;

    localparam int S = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] sw_in = 3'b000;
    logic [2:0] sw_out;
    logic       changed;
`ifdef DEBOUNCE_EVENT_CNT_EN
    logic [7:0] evt_cnt;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    switch_debounce3 #(.STABLE_CYCLES(S), .CNT_WIDTH(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .sw_in   (sw_in),
        .sw_out  (sw_out),
        .changed (changed)
`ifdef DEBOUNCE_EVENT_CNT_EN
        ,
        .evt_cnt (evt_cnt)
`endif
    );

    // Reference: the input reaches the decision point two edges after it is
    // presented; an output bit flips once that delayed level has disagreed
    // with it on S consecutive edges.
    typedef struct packed {
        logic [2:0]      d1;
        logic [2:0]      d2;
        logic [2:0]      out;
        logic            chg;
        logic [7:0]      evt;
        logic [2:0][7:0] run;
    } mstate_t;

    mstate_t m = '0;

    function automatic mstate_t model_step(mstate_t s, logic [2:0] in, logic rst);
        mstate_t n;
        n = s;
        if (rst) begin
            n = '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (s.d2[i] != s.out[i]) begin
                    n.run[i] = s.run[i] + 8'd1;
                    if (int'(n.run[i]) == S) begin
                        n.out[i] = s.d2[i];
                        n.run[i] = 8'd0;
                    end
                end else begin
                    n.run[i] = 8'd0;
                end
            end
            n.chg = (n.out != s.out);
            n.evt = s.evt + (n.chg ? 8'd1 : 8'd0);
            n.d2  = s.d1;
            n.d1  = in;
        end
        return n;
    endfunction

    always @(posedge clk) m <= model_step(m, sw_in, reset);

    task automatic do_reset();
        reset = 1'b1;
        sw_in = 3'b000;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        sw_in = 3'b111;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (sw_out !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_sw_out got=%b want=000", sw_out);
        end
        n_cmp++;
        if (changed !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_changed got=%b want=0", changed);
        end
`ifdef DEBOUNCE_EVENT_CNT_EN
        n_cmp++;
        if (evt_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_evt_cnt got=%0d want=0", evt_cnt);
        end
`endif
        reset = 1'b0;
        sw_in = 3'b000;
    endtask

    task automatic test_latency();
        do_reset();
        sw_in = 3'b011;
        for (int e = 1; e <= 9; e++) begin
            @(negedge clk);
            n_cmp++;
            if (sw_out !== ((e >= S + 2) ? 3'b011 : 3'b000)) begin
                n_fail++;
                $display("FAIL latency_sw_out edge=%0d got=%b want=%b", e, sw_out,
                         (e >= S + 2) ? 3'b011 : 3'b000);
            end
            n_cmp++;
            if (changed !== (e == S + 2)) begin
                n_fail++;
                $display("FAIL latency_changed edge=%0d got=%b want=%b", e, changed, (e == S + 2));
            end
        end
    endtask

    task automatic test_bounce();
        do_reset();
        sw_in = 3'b001;
        repeat (2) @(negedge clk);
        sw_in = 3'b000;
        for (int e = 0; e < 12; e++) begin
            @(negedge clk);
            n_cmp++;
            if (sw_out !== 3'b000 || changed !== 1'b0) begin
                n_fail++;
                $display("FAIL bounce cyc=%0d got sw_out=%b changed=%b want 000/0", e, sw_out, changed);
            end
        end
    endtask

    task automatic test_bounce_settle();
        do_reset();
        sw_in = 3'b100; @(negedge clk);
        sw_in = 3'b000; @(negedge clk);
        sw_in = 3'b100; @(negedge clk); // final 1 sampled on this edge (edge 1)
        for (int e = 2; e <= 8; e++) begin
            @(negedge clk);
            n_cmp++;
            if (sw_out !== ((e >= S + 2) ? 3'b100 : 3'b000)) begin
                n_fail++;
                $display("FAIL settle_sw_out edge=%0d got=%b want=%b", e, sw_out,
                         (e >= S + 2) ? 3'b100 : 3'b000);
            end
            n_cmp++;
            if (changed !== (e == S + 2)) begin
                n_fail++;
                $display("FAIL settle_changed edge=%0d got=%b want=%b", e, changed, (e == S + 2));
            end
        end
    endtask

    task automatic test_simultaneous();
        int pulses;
        logic [7:0] evt0;
        pulses = 0;
        do_reset();
        evt0 = m.evt;
        sw_in = 3'b111;
        for (int e = 1; e <= 10; e++) begin
            @(negedge clk);
            if (changed === 1'b1) pulses++;
            n_cmp++;
            if (sw_out !== ((e >= S + 2) ? 3'b111 : 3'b000)) begin
                n_fail++;
                $display("FAIL simul_sw_out edge=%0d got=%b want=%b", e, sw_out,
                         (e >= S + 2) ? 3'b111 : 3'b000);
            end
        end
        n_cmp++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL simul_pulses got=%0d want=1", pulses);
        end
`ifdef DEBOUNCE_EVENT_CNT_EN
        n_cmp++;
        if (evt_cnt !== evt0 + 8'd1) begin
            n_fail++;
            $display("FAIL simul_evt_cnt got=%0d want=%0d", evt_cnt, evt0 + 8'd1);
        end
`endif
    endtask

    task automatic test_reset_midcount();
        do_reset();
        sw_in = 3'b111;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (sw_out !== 3'b000 || changed !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_hold got sw_out=%b changed=%b want 000/0", sw_out, changed);
        end
        reset = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            @(negedge clk);
            n_cmp++;
            if (sw_out !== ((e >= S + 2) ? 3'b111 : 3'b000)) begin
                n_fail++;
                $display("FAIL midreset_sw_out edge=%0d got=%b want=%b", e, sw_out,
                         (e >= S + 2) ? 3'b111 : 3'b000);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int seg = 0; seg < 300; seg++) begin
            sw_in = 3'($urandom_range(0, 7));
            for (int h = 0; h < int'($urandom_range(1, 8)); h++) begin
                @(negedge clk);
                n_cmp++;
                if (sw_out !== m.out || changed !== m.chg) begin
                    n_fail++;
                    $display("FAIL random seg=%0d got sw_out=%b changed=%b want %b/%b",
                             seg, sw_out, changed, m.out, m.chg);
                end
`ifdef DEBOUNCE_EVENT_CNT_EN
                n_cmp++;
                if (evt_cnt !== m.evt) begin
                    n_fail++;
                    $display("FAIL random_evt seg=%0d got=%0d want=%0d", seg, evt_cnt, m.evt);
                end
`endif
            end
        end
    endtask

`ifdef DEBOUNCE_EVENT_CNT_EN
    task automatic test_wrap();
        bit seen;
        do_reset();
        for (int k = 1; k <= 256; k++) begin
            sw_in = {2'b00, ~m.out[0]};
            seen = 1'b0;
            for (int c = 0; c < 20 && !seen; c++) begin
                @(negedge clk);
                if (changed === 1'b1) seen = 1'b1;
            end
            n_cmp++;
            if (!seen) begin
                n_fail++;
                $display("FAIL wrap_timeout toggle=%0d got no change want change", k);
            end
            if (k == 255 || k == 256) begin
                n_cmp++;
                if (evt_cnt !== 8'(k)) begin
                    n_fail++;
                    $display("FAIL wrap_evt toggle=%0d got=%0d want=%0d", k, evt_cnt, 8'(k));
                end
            end
        end
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_latency();
        test_bounce();
        test_bounce_settle();
        test_simultaneous();
        test_reset_midcount();
        test_random();
`ifdef DEBOUNCE_EVENT_CNT_EN
        test_wrap();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
